// File: rtl/rv_pipe_pkg.sv
// Shared MEM->WB pipeline definitions: default widths and writeback payload layout.
// Payload is packed as {alu_result, mem_data, rd, reg_write, mem_to_reg}, LSB last.
package rv_pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned RA_W_DEF = 5;

    localparam int unsigned OFF_M2R = 0;
    localparam int unsigned OFF_WE  = 1;
    localparam int unsigned OFF_RD  = 2;

    function automatic int unsigned wb_payload_w(int unsigned xlen, int unsigned ra_w);
        return 2 * xlen + ra_w + 2;
    endfunction

    function automatic int unsigned off_mem(int unsigned ra_w);
        return OFF_RD + ra_w;
    endfunction

    function automatic int unsigned off_alu(int unsigned xlen, int unsigned ra_w);
        return OFF_RD + ra_w + xlen;
    endfunction

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// Handshake and payload bundle for the MEM->WB stage; the stage sits on the slave modport,
// the memory stage / writeback driver on the master modport.
interface mem_wb_pipe_stage_if
    import rv_pipe_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned RA_W = RA_W_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] alu_result_in;
    logic [XLEN-1:0] mem_data_in;
    logic [RA_W-1:0] rd_in;
    logic            reg_write_in;
    logic            mem_to_reg_in;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] mem_data_out;
    logic [RA_W-1:0] rd_out;
    logic            reg_write_out;
    logic            mem_to_reg_out;
    logic [XLEN-1:0] wb_data_out;

    modport master (
        output in_valid, alu_result_in, mem_data_in, rd_in, reg_write_in, mem_to_reg_in,
        input  in_ready,
        input  out_valid, alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out,
        input  wb_data_out,
        output out_ready
    );

    modport slave (
        input  in_valid, alu_result_in, mem_data_in, rd_in, reg_write_in, mem_to_reg_in,
        output in_ready,
        output out_valid, alu_result_out, mem_data_out, rd_out, reg_write_out, mem_to_reg_out,
        output wb_data_out,
        input  out_ready
    );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline slot: payload register plus valid bit. load wins over clear; payload holds
// its value when cleared so only the valid bit changes.
module pipe_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, synchronous flush, optional skid slot
// and the writeback data mux driven from the main slot.
module mem_wb_pipe_stage
    import rv_pipe_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEF,
    parameter int unsigned RA_W       = RA_W_DEF,
    parameter int unsigned SKID       = 1,
    parameter int unsigned ZERO_RD_WE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    mem_wb_pipe_stage_if.slave  bus,
    output logic [1:0]          occupancy
);

    localparam int unsigned WB_PAYLOAD_W = wb_payload_w(XLEN, RA_W);
    localparam int unsigned OffMem       = off_mem(RA_W);
    localparam int unsigned OffAlu       = off_alu(XLEN, RA_W);

    logic                    accept, drain, move;
    logic                    main_valid, main_load, main_clear;
    logic                    skid_valid, skid_load, skid_clear;
    logic [WB_PAYLOAD_W-1:0] in_payload, main_d, main_q, skid_q;
    logic                    rd_ok;

    assign in_payload = {bus.alu_result_in, bus.mem_data_in, bus.rd_in,
                         bus.reg_write_in, bus.mem_to_reg_in};

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = main_valid & bus.out_ready;
    assign move   = drain & skid_valid;

    // Steering: the skid beat is older than anything offered, so it refills main first.
    always_comb begin
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_payload;
        main_clear = flush | drain;
        skid_clear = flush | move;
        if (!flush) begin
            if (move) begin
                main_load = 1'b1;
                main_d    = skid_q;
            end else if (accept && (!main_valid || drain)) begin
                main_load = 1'b1;
            end
            if (accept && main_valid && !drain) begin
                skid_load = 1'b1;
            end
        end
    end

    pipe_slot #(.W(WB_PAYLOAD_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_slot #(.W(WB_PAYLOAD_W)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_payload),
            .valid (skid_valid),
            .q     (skid_q)
        );
        // Registered ready: no combinational path from out_ready.
        assign bus.in_ready = ~skid_valid;
    end else begin : g_no_skid
        assign skid_valid   = 1'b0;
        assign skid_q       = '0;
        assign bus.in_ready = ~main_valid | bus.out_ready;
    end

    assign bus.out_valid      = main_valid;
    assign bus.alu_result_out = main_q[OffAlu +: XLEN];
    assign bus.mem_data_out   = main_q[OffMem +: XLEN];
    assign bus.rd_out         = main_q[OFF_RD +: RA_W];
    assign bus.mem_to_reg_out = main_q[OFF_M2R];

    assign rd_ok             = (ZERO_RD_WE != 0) | (|bus.rd_out);
    assign bus.reg_write_out = main_q[OFF_WE] & main_valid & rd_ok;
    assign bus.wb_data_out   = bus.mem_to_reg_out ? bus.mem_data_out : bus.alu_result_out;

    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: a SKID=1 and a SKID=0 instance, scoreboard queues per instance
// fed on accept and checked on drain, plus per-scenario cycle-accurate checks.
module tb_mem_wb_pipe_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [4:0]  rd;
        logic        we;
        logic        m2r;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush1 = 1'b0;
    logic       flush0 = 1'b0;
    logic [1:0] occ1, occ0;

    int n_checks = 0;
    int n_fail   = 0;

    beat_t q1[$];
    beat_t q0[$];
    beat_t e1, e0;
    logic [102:0] obs1, want1, obs0, want0;

    mem_wb_pipe_stage_if #(.XLEN(32), .RA_W(5)) bus1 ();
    mem_wb_pipe_stage_if #(.XLEN(32), .RA_W(5)) bus0 ();

    mem_wb_pipe_stage #(.XLEN(32), .RA_W(5), .SKID(1), .ZERO_RD_WE(0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush1),
        .bus       (bus1.slave),
        .occupancy (occ1)
    );

    mem_wb_pipe_stage #(.XLEN(32), .RA_W(5), .SKID(0), .ZERO_RD_WE(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush0),
        .bus       (bus0.slave),
        .occupancy (occ0)
    );

    always #5 clk = ~clk;

    // Scoreboards: compare the drained beat first, then flush discards the queue and any
    // beat accepted on the same edge.
    always @(negedge clk) begin
        if (rst) begin
            if (bus1.out_valid && bus1.out_ready) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb1_unexpected_beat got alu=%h want no beat",
                             bus1.alu_result_out);
                end else begin
                    e1    = q1.pop_front();
                    obs1  = {bus1.alu_result_out, bus1.mem_data_out, bus1.rd_out,
                             bus1.mem_to_reg_out, bus1.wb_data_out, bus1.reg_write_out};
                    want1 = {e1.alu, e1.mem, e1.rd, e1.m2r, (e1.m2r ? e1.mem : e1.alu),
                             (e1.we && (e1.rd != 5'd0))};
                    if (obs1 !== want1) begin
                        n_fail++;
                        $display("FAIL sb1_beat got=%h want=%h", obs1, want1);
                    end
                end
            end
            if (flush1) q1.delete();
            else if (bus1.in_valid && bus1.in_ready)
                q1.push_back('{bus1.alu_result_in, bus1.mem_data_in, bus1.rd_in,
                               bus1.reg_write_in, bus1.mem_to_reg_in});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus0.out_valid && bus0.out_ready) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb0_unexpected_beat got alu=%h want no beat",
                             bus0.alu_result_out);
                end else begin
                    e0    = q0.pop_front();
                    obs0  = {bus0.alu_result_out, bus0.mem_data_out, bus0.rd_out,
                             bus0.mem_to_reg_out, bus0.wb_data_out, bus0.reg_write_out};
                    want0 = {e0.alu, e0.mem, e0.rd, e0.m2r, (e0.m2r ? e0.mem : e0.alu),
                             (e0.we && (e0.rd != 5'd0))};
                    if (obs0 !== want0) begin
                        n_fail++;
                        $display("FAIL sb0_beat got=%h want=%h", obs0, want0);
                    end
                end
            end
            if (flush0) q0.delete();
            else if (bus0.in_valid && bus0.in_ready)
                q0.push_back('{bus0.alu_result_in, bus0.mem_data_in, bus0.rd_in,
                               bus0.reg_write_in, bus0.mem_to_reg_in});
        end
    end

    task automatic drive1(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] rd, input logic we, input logic m2r);
        bus1.in_valid      = v;
        bus1.alu_result_in = alu;
        bus1.mem_data_in   = mem;
        bus1.rd_in         = rd;
        bus1.reg_write_in  = we;
        bus1.mem_to_reg_in = m2r;
    endtask

    task automatic drive0(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                          input logic [4:0] rd, input logic we, input logic m2r);
        bus0.in_valid      = v;
        bus0.alu_result_in = alu;
        bus0.mem_data_in   = mem;
        bus0.rd_in         = rd;
        bus0.reg_write_in  = we;
        bus0.mem_to_reg_in = m2r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive1(1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd9, 1'b1, 1'b1);
        drive0(1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd9, 1'b1, 1'b1);
        bus1.out_ready = 1'b1;
        bus0.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus1.out_valid, bus1.in_ready, occ1} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_hs1 got v/r/occ=%b want 0100",
                     {bus1.out_valid, bus1.in_ready, occ1});
        end
        n_checks++;
        if ({bus1.alu_result_out, bus1.mem_data_out, bus1.rd_out, bus1.reg_write_out,
             bus1.mem_to_reg_out, bus1.wb_data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_out1 got alu=%h mem=%h rd=%h wb=%h want all 0",
                     bus1.alu_result_out, bus1.mem_data_out, bus1.rd_out, bus1.wb_data_out);
        end
        n_checks++;
        if ({bus0.out_valid, bus0.in_ready, occ0, bus0.wb_data_out} !== {4'b0100, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_hs0 got v/r/occ=%b wb=%h want 0100 0",
                     {bus0.out_valid, bus0.in_ready, occ0}, bus0.wb_data_out);
        end
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drive0(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            drive1(1'b1, 32'h11 + i, 32'h100 + i, 5'(i + 1), 1'b1, 1'b0);
            @(negedge clk);
            n_checks++;
            if (bus1.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready beat=%0d got=%b want=1", i, bus1.in_ready);
            end
            if (i > 0) begin
                n_checks++;
                if ({bus1.out_valid, bus1.alu_result_out} !== {1'b1, 32'h11 + 32'(i - 1)}) begin
                    n_fail++;
                    $display("FAIL stream_out beat=%0d got v=%b alu=%h want v=1 alu=%h", i,
                             bus1.out_valid, bus1.alu_result_out, 32'h11 + 32'(i - 1));
                end
            end
        end
        step();
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus1.out_valid, bus1.alu_result_out, bus1.rd_out} !== {1'b1, 32'h14, 5'd4}) begin
            n_fail++;
            $display("FAIL stream_last got v=%b alu=%h rd=%0d want v=1 alu=14 rd=4",
                     bus1.out_valid, bus1.alu_result_out, bus1.rd_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus1.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_empty got out_valid=%b want 0", bus1.out_valid);
        end
    endtask

    task automatic test_backpressure();
        step();
        bus1.out_ready = 1'b0;
        drive1(1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
        step();
        drive1(1'b1, 32'hB0, 32'hB1, 5'd11, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({occ1, bus1.in_ready, bus1.alu_result_out} !== {2'd1, 1'b1, 32'hA0}) begin
            n_fail++;
            $display("FAIL bp_one got occ=%0d rdy=%b alu=%h want 1 1 a0", occ1,
                     bus1.in_ready, bus1.alu_result_out);
        end
        step();
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({occ1, bus1.in_ready, bus1.alu_result_out} !== {2'd2, 1'b0, 32'hA0}) begin
            n_fail++;
            $display("FAIL bp_full got occ=%0d rdy=%b alu=%h want 2 0 a0", occ1,
                     bus1.in_ready, bus1.alu_result_out);
        end
        step();
        bus1.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus1.out_valid, bus1.in_ready, bus1.alu_result_out} !== {2'b10, 32'hA0}) begin
            n_fail++;
            $display("FAIL bp_drain_a got v=%b rdy=%b alu=%h want 1 0 a0", bus1.out_valid,
                     bus1.in_ready, bus1.alu_result_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({occ1, bus1.in_ready, bus1.alu_result_out} !== {2'd1, 1'b1, 32'hB0}) begin
            n_fail++;
            $display("FAIL bp_drain_b got occ=%0d rdy=%b alu=%h want 1 1 b0", occ1,
                     bus1.in_ready, bus1.alu_result_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (occ1 !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_empty got occ=%0d want 0", occ1);
        end
    endtask

    task automatic test_flush();
        step();
        bus1.out_ready = 1'b0;
        drive1(1'b1, 32'hD0, 32'hD1, 5'd12, 1'b1, 1'b0);
        step();
        drive1(1'b1, 32'hE0, 32'hE1, 5'd13, 1'b1, 1'b0);
        step();
        flush1 = 1'b1;
        drive1(1'b1, 32'hC0, 32'hC1, 5'd14, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({occ1, bus1.in_ready} !== {2'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_pre got occ=%0d rdy=%b want 2 0", occ1, bus1.in_ready);
        end
        step();
        flush1 = 1'b0;
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus1.out_valid, occ1, bus1.reg_write_out, bus1.in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL flush_full got v=%b occ=%0d we=%b rdy=%b want 0 0 0 1",
                     bus1.out_valid, occ1, bus1.reg_write_out, bus1.in_ready);
        end
        drive1(1'b1, 32'hF0, 32'hF1, 5'd15, 1'b1, 1'b0);
        step();
        flush1 = 1'b1;
        drive1(1'b1, 32'hC2, 32'hC3, 5'd16, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({occ1, bus1.in_ready} !== {2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_accept_pre got occ=%0d rdy=%b want 1 1", occ1, bus1.in_ready);
        end
        step();
        flush1 = 1'b0;
        bus1.out_ready = 1'b1;
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus1.out_valid, occ1, bus1.reg_write_out} !== 4'b0000) begin
                n_fail++;
                $display("FAIL flush_discard cyc=%0d got v=%b occ=%0d we=%b want 0 0 0", i,
                         bus1.out_valid, occ1, bus1.reg_write_out);
            end
            step();
        end
    endtask

    task automatic test_wb_mux();
        bus1.out_ready = 1'b1;
        drive1(1'b1, 32'h5, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1);
        step();
        drive1(1'b1, 32'h77, 32'h99, 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus1.wb_data_out, bus1.reg_write_out} !== {32'hDEAD_BEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL wb_mem got wb=%h we=%b want deadbeef 1", bus1.wb_data_out,
                     bus1.reg_write_out);
        end
        step();
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus1.out_valid, bus1.wb_data_out, bus1.reg_write_out} !== {1'b1, 32'h77, 1'b0}) begin
            n_fail++;
            $display("FAIL wb_rd0 got v=%b wb=%h we=%b want 1 77 0", bus1.out_valid,
                     bus1.wb_data_out, bus1.reg_write_out);
        end
        step();
    endtask

    task automatic test_skid0();
        bus0.out_ready = 1'b0;
        drive0(1'b1, 32'h50, 32'h51, 5'd20, 1'b1, 1'b0);
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL s0_empty_ready got=%b want 1", bus0.in_ready);
        end
        step();
        drive0(1'b1, 32'h60, 32'h61, 5'd21, 1'b1, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({bus0.out_valid, bus0.in_ready, occ0, bus0.alu_result_out} !==
            {4'b1001, 32'h50}) begin
            n_fail++;
            $display("FAIL s0_stall got v=%b rdy=%b occ=%0d alu=%h want 1 0 1 50",
                     bus0.out_valid, bus0.in_ready, occ0, bus0.alu_result_out);
        end
        step();
        bus0.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL s0_comb_ready got=%b want 1", bus0.in_ready);
        end
        step();
        drive0(1'b0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus0.out_valid, bus0.alu_result_out, bus0.wb_data_out} !==
            {1'b1, 32'h60, 32'h61}) begin
            n_fail++;
            $display("FAIL s0_next got v=%b alu=%h wb=%h want 1 60 61", bus0.out_valid,
                     bus0.alu_result_out, bus0.wb_data_out);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL s0_empty got v=%b want 0", bus0.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        step();
        bus1.out_ready = 1'b0;
        drive1(1'b1, 32'h70, 32'h71, 5'd3, 1'b1, 1'b0);
        step();
        drive1(1'b1, 32'h80, 32'h81, 5'd4, 1'b1, 1'b0);
        step();
        drive1(1'b0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus1.out_valid, occ1, bus1.in_ready, bus1.wb_data_out} !== {4'b0001, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b occ=%0d rdy=%b wb=%h want 0 0 1 0",
                     bus1.out_valid, occ1, bus1.in_ready, bus1.wb_data_out);
        end
        q1.delete();
        q0.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus1.out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wb_mux();
        test_skid0();
        test_reset_mid();
        repeat (2) step();
        n_checks++;
        if ((q1.size() + q0.size()) != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got %0d/%0d beats pending want 0/0", q1.size(),
                     q0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
